// File: rtl/echo_txrx_if.sv
// Handshake bundle between the sequencing controller and the echo_txrx responder.
// The slave side is the responder; the master side is the controller/transducer front end.
interface echo_txrx_if #(
    parameter int CNT_W = 24
) ();
    logic             en_tx;
    logic             over_tx;
    logic             tx_out;
    logic             en_re;
    logic             echo_in;
    logic             over_re;
    logic [CNT_W-1:0] echo_cnt;
    logic             echo_timeout;
    logic             busy;

    modport slave (
        input  en_tx,
        input  en_re,
        input  echo_in,
        output over_tx,
        output tx_out,
        output over_re,
        output echo_cnt,
        output echo_timeout,
        output busy
    );

    modport master (
        output en_tx,
        output en_re,
        output echo_in,
        input  over_tx,
        input  tx_out,
        input  over_re,
        input  echo_cnt,
        input  echo_timeout,
        input  busy
    );
endinterface

// File: rtl/echo_txrx.sv
// Transmit-burst generator and echo timestamp receiver answering the controller's
// en_tx/over_tx and en_re/over_re handshakes.
module echo_txrx #(
    parameter int DIV_HALF  = 1250,
    parameter int BURST_CYC = 8,
    parameter int BLANK_CYC = 5000,
    parameter int WIN_CYC   = 1000000,
    parameter int CNT_W     = 24
) (
    input  logic        i_clk_100,
    input  logic        i_rst,
    echo_txrx_if.slave  io_bus
);
    // state  | meaning
    // S_IDLE | waiting for en_tx (priority) or en_re
    // S_TX   | driving the square-wave burst on tx_out
    // S_RX   | receive window open, counting and watching for an echo edge
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_TX   = 2'd1,
        S_RX   = 2'd2
    } state_t;

    localparam int DIV_W  = (DIV_HALF > 1) ? $clog2(DIV_HALF) : 1;
    localparam int HALF_W = (2 * BURST_CYC > 1) ? $clog2(2 * BURST_CYC) : 1;

    localparam logic [DIV_W-1:0]  DIV_LOAD  = DIV_W'(DIV_HALF - 1);
    localparam logic [HALF_W-1:0] HALF_LOAD = HALF_W'(2 * BURST_CYC - 1);
    localparam logic [CNT_W-1:0]  CNT_BLANK = CNT_W'(BLANK_CYC);
    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(WIN_CYC - 1);

    state_t            r_state;
    state_t            w_state_nxt;
    logic [DIV_W-1:0]  r_div;
    logic [DIV_W-1:0]  w_div_nxt;
    logic [HALF_W-1:0] r_half;
    logic [HALF_W-1:0] w_half_nxt;
    logic [CNT_W-1:0]  r_rx_cnt;
    logic [CNT_W-1:0]  w_rx_cnt_nxt;
    logic              r_tx_out;
    logic              w_tx_out_nxt;
    logic              r_over_tx;
    logic              w_over_tx_nxt;
    logic              r_over_re;
    logic              w_over_re_nxt;
    logic [CNT_W-1:0]  r_echo_cnt;
    logic [CNT_W-1:0]  w_echo_cnt_nxt;
    logic              r_echo_to;
    logic              w_echo_to_nxt;

    logic              r_sync1;
    logic              r_sync2;
    logic              r_prev;
    logic              w_edge;
    logic              w_edge_ok;

    // Flops preset to 1 so a comparator already high at reset release is not an edge.
    always_ff @(posedge i_clk_100) begin
        if (i_rst) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
            r_prev  <= 1'b1;
        end else begin
            r_sync1 <= io_bus.echo_in;
            r_sync2 <= r_sync1;
            r_prev  <= r_sync2;
        end
    end

    assign w_edge    = r_sync2 & ~r_prev;
    assign w_edge_ok = w_edge && (r_rx_cnt >= CNT_BLANK);

    always_ff @(posedge i_clk_100) begin
        if (i_rst) begin
            r_state    <= S_IDLE;
            r_div      <= '0;
            r_half     <= '0;
            r_rx_cnt   <= '0;
            r_tx_out   <= 1'b0;
            r_over_tx  <= 1'b0;
            r_over_re  <= 1'b0;
            r_echo_cnt <= '0;
            r_echo_to  <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_div      <= w_div_nxt;
            r_half     <= w_half_nxt;
            r_rx_cnt   <= w_rx_cnt_nxt;
            r_tx_out   <= w_tx_out_nxt;
            r_over_tx  <= w_over_tx_nxt;
            r_over_re  <= w_over_re_nxt;
            r_echo_cnt <= w_echo_cnt_nxt;
            r_echo_to  <= w_echo_to_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_div_nxt      = r_div;
        w_half_nxt     = r_half;
        w_rx_cnt_nxt   = r_rx_cnt;
        w_tx_out_nxt   = r_tx_out;
        w_over_tx_nxt  = 1'b0;
        w_over_re_nxt  = 1'b0;
        w_echo_cnt_nxt = r_echo_cnt;
        w_echo_to_nxt  = r_echo_to;

        case (r_state)
            S_IDLE: begin
                if (io_bus.en_tx) begin
                    w_state_nxt  = S_TX;
                    w_tx_out_nxt = 1'b1;
                    w_div_nxt    = DIV_LOAD;
                    w_half_nxt   = HALF_LOAD;
                end else if (io_bus.en_re) begin
                    w_state_nxt  = S_RX;
                    w_rx_cnt_nxt = '0;
                end
            end

            // r_div counts down the current half-period, r_half the half-periods left.
            S_TX: begin
                if (r_div == '0) begin
                    if (r_half == '0) begin
                        w_tx_out_nxt  = 1'b0;
                        w_over_tx_nxt = 1'b1;
                        w_state_nxt   = S_IDLE;
                    end else begin
                        w_div_nxt    = DIV_LOAD;
                        w_half_nxt   = r_half - HALF_W'(1);
                        w_tx_out_nxt = ~r_tx_out;
                    end
                end else begin
                    w_div_nxt = r_div - DIV_W'(1);
                end
            end

            // An edge on the final window cycle is checked first so it beats the timeout.
            S_RX: begin
                if (w_edge_ok) begin
                    w_echo_cnt_nxt = r_rx_cnt;
                    w_echo_to_nxt  = 1'b0;
                    w_over_re_nxt  = 1'b1;
                    w_state_nxt    = S_IDLE;
                end else if (r_rx_cnt == CNT_LAST) begin
                    w_echo_cnt_nxt = '0;
                    w_echo_to_nxt  = 1'b1;
                    w_over_re_nxt  = 1'b1;
                    w_state_nxt    = S_IDLE;
                end else begin
                    w_rx_cnt_nxt = r_rx_cnt + CNT_W'(1);
                end
            end

            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign io_bus.tx_out       = r_tx_out;
    assign io_bus.over_tx      = r_over_tx;
    assign io_bus.over_re      = r_over_re;
    assign io_bus.echo_cnt     = r_echo_cnt;
    assign io_bus.echo_timeout = r_echo_to;
    assign io_bus.busy         = (r_state != S_IDLE);

endmodule

// File: tb/tb_echo_txrx.sv
// Bench for echo_txrx: directed handshake cases plus randomized echo waveforms,
// each scored against a cycle-index model of the burst shape and echo timestamp.
module tb_echo_txrx;
    localparam int DH    = 4;
    localparam int BC    = 2;
    localparam int BLANK = 10;
    localparam int WIN   = 100;
    localparam int CW    = 8;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    echo_txrx_if #(.CNT_W(CW)) tif ();

    echo_txrx #(
        .DIV_HALF (DH),
        .BURST_CYC(BC),
        .BLANK_CYC(BLANK),
        .WIN_CYC  (WIN),
        .CNT_W    (CW)
    ) dut (
        .i_clk_100(clk),
        .i_rst    (rst),
        .io_bus   (tif.slave)
    );

    int n_total = 0;
    int n_bad   = 0;
    int n_otx   = 0;
    int n_ore   = 0;
    bit w[128];

    always @(negedge clk) begin
        if (tif.over_tx) n_otx++;
        if (tif.over_re) n_ore++;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, want %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // First cycle index k in the window where the synchronized echo shows a
    // rising edge (value driven after edge k-2 high, after k-3 low) and k >= BLANK.
    function automatic void model(input bit pre, output int k_exp, output bit to_exp);
        bit s2;
        bit pv;
        k_exp  = WIN - 1;
        to_exp = 1'b1;
        for (int k = BLANK; k < WIN; k++) begin
            s2 = (k - 2 < 0) ? pre : w[k-2];
            pv = (k - 3 < 0) ? pre : w[k-3];
            if (s2 && !pv) begin
                k_exp  = k;
                to_exp = 1'b0;
                break;
            end
        end
    endfunction

    task automatic fill_step(input bit pre, input int rise);
        for (int k = 0; k < 128; k++) w[k] = (k >= rise) ? 1'b1 : pre;
    endtask

    task automatic run_rx(input string tag, input bit pre);
        int k_exp;
        bit to_exp;
        int k_obs;
        int ore0;
        model(pre, k_exp, to_exp);
        tif.echo_in = pre;
        repeat (4) tick();
        ore0 = n_ore;
        tif.en_re = 1'b1;
        tick();
        tif.en_re   = 1'b0;
        tif.echo_in = w[0];
        chk({tag, "_busy"}, 32'(tif.busy), 32'd1);
        k_obs = -1;
        for (int k = 1; k <= WIN + 5; k++) begin
            tick();
            if (tif.over_re) begin
                k_obs = k;
                break;
            end
            tif.echo_in = w[k];
        end
        chk({tag, "_lat"}, 32'(k_obs), 32'(k_exp + 1));
        chk({tag, "_cnt"}, 32'(tif.echo_cnt), to_exp ? 32'd0 : 32'(k_exp));
        chk({tag, "_to"}, 32'(tif.echo_timeout), 32'(to_exp));
        chk({tag, "_idle"}, 32'(tif.busy), 32'd0);
        tick();
        chk({tag, "_pulse"}, 32'(tif.over_re), 32'd0);
        chk({tag, "_npulse"}, 32'(n_ore - ore0), 32'd1);
    endtask

    task automatic run_tx(input string tag, input bit both, input int mid_re);
        bit exp_tx;
        int otx0;
        otx0 = n_otx;
        tif.en_tx = 1'b1;
        tif.en_re = both;
        tick();
        tif.en_tx = 1'b0;
        tif.en_re = 1'b0;
        for (int j = 0; j <= 2 * BC * DH; j++) begin
            if (j > 0) tick();
            tif.en_re = (j == mid_re);
            exp_tx = (j < 2 * BC * DH) && (((j / DH) % 2) == 0);
            chk($sformatf("%s_tx%0d", tag, j), 32'(tif.tx_out), 32'(exp_tx));
            chk($sformatf("%s_otx%0d", tag, j), 32'(tif.over_tx), 32'(j == 2 * BC * DH));
            chk($sformatf("%s_busy%0d", tag, j), 32'(tif.busy), 32'(j < 2 * BC * DH));
        end
        tif.en_re = 1'b0;
        tick();
        chk({tag, "_otx_end"}, 32'(tif.over_tx), 32'd0);
        chk({tag, "_notx"}, 32'(n_otx - otx0), 32'd1);
    endtask

    initial begin
        bit pre;
        int ore0;
        int otx0;
        int busy_cnt;
        int rise;

        rst         = 1'b1;
        tif.en_tx   = 1'b0;
        tif.en_re   = 1'b0;
        tif.echo_in = 1'b1;

        // 1: reset with comparator high, then a receive that must see no echo
        repeat (5) tick();
        chk("rst_tx", 32'(tif.tx_out), 32'd0);
        chk("rst_otx", 32'(tif.over_tx), 32'd0);
        chk("rst_ore", 32'(tif.over_re), 32'd0);
        chk("rst_cnt", 32'(tif.echo_cnt), 32'd0);
        chk("rst_to", 32'(tif.echo_timeout), 32'd0);
        chk("rst_busy", 32'(tif.busy), 32'd0);
        rst = 1'b0;
        fill_step(1'b1, 0);
        run_rx("t1", 1'b1);

        // 2: plain burst
        run_tx("t2", 1'b0, -1);

        // 3: echo rising just after E40
        fill_step(1'b0, 40);
        run_rx("t3", 1'b0);

        // 4: pulse inside blanking only
        for (int k = 0; k < 128; k++) w[k] = (k >= 5 && k <= 8);
        run_rx("t4", 1'b0);

        // window boundaries: blank edge, last-cycle edge, one past the end
        fill_step(1'b0, 8);
        run_rx("b_blank_in", 1'b0);
        fill_step(1'b0, 7);
        run_rx("b_blank_out", 1'b0);
        fill_step(1'b0, 97);
        run_rx("b_last", 1'b0);
        fill_step(1'b0, 98);
        run_rx("b_late", 1'b0);

        // randomized echo waveforms
        for (int t = 0; t < 10; t++) begin
            if (t % 2 == 0) begin
                pre  = 1'b0;
                rise = $urandom_range(0, 110);
                fill_step(pre, rise);
            end else begin
                pre = 1'($urandom_range(0, 1));
                begin
                    bit v;
                    v = pre;
                    for (int k = 0; k < 128; k++) begin
                        if ($urandom_range(0, 15) == 0) v = ~v;
                        w[k] = v;
                    end
                end
            end
            run_rx($sformatf("rnd%0d", t), pre);
        end

        // leave a timeout result latched so hold and reset clearing are visible
        for (int k = 0; k < 128; k++) w[k] = 1'b0;
        run_rx("pre5", 1'b0);

        // 5: simultaneous requests and an en_re during the burst
        ore0 = n_ore;
        run_tx("t5", 1'b1, 8);
        busy_cnt = 0;
        for (int c = 0; c < WIN + 10; c++) begin
            tick();
            if (tif.busy) busy_cnt++;
        end
        chk("t5_no_rx_busy", 32'(busy_cnt), 32'd0);
        chk("t5_no_ore", 32'(n_ore - ore0), 32'd0);
        chk("t5_hold_to", 32'(tif.echo_timeout), 32'd1);

        // 6: reset in the middle of a burst
        otx0 = n_otx;
        tif.en_tx = 1'b1;
        tick();
        tif.en_tx = 1'b0;
        repeat (6) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("t6_tx", 32'(tif.tx_out), 32'd0);
        chk("t6_busy", 32'(tif.busy), 32'd0);
        chk("t6_otx", 32'(tif.over_tx), 32'd0);
        chk("t6_to_clr", 32'(tif.echo_timeout), 32'd0);
        chk("t6_cnt_clr", 32'(tif.echo_cnt), 32'd0);
        repeat (20) tick();
        chk("t6_no_otx", 32'(n_otx - otx0), 32'd0);
        run_tx("t6b", 1'b0, -1);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
